dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single-port data RAM behind the data cache between two requesters: port 0 is the cache fill/writeback engine and port 1 is the I/O transfer engine that moves input_bus/output_bus bytes.
- Sequences every RAM access with a fixed-latency enable window.
- Returns read data and a one-cycle done strobe to the winning requester.
- Arbitration is round-robin on contention.

Parameters:
ADDR_W, 8, address width
DATA_W, 8, data width
MEM_LAT, 2, cycles mem_en held per access (legal 1..7)

Ports:
g_clk  in  1  global clock, rising edge
g_clr  in  1  global reset, asynchronous, active-low
r0_req  in  1  port 0 request, held until r0_done
r0_rw  in  1  port 0 direction, 1=write 0=read
r0_addr  in  ADDR_W  port 0 address
r0_wdata  in  DATA_W  port 0 write data
r0_gnt  out  1  port 0 owns RAM (access in progress)
r0_done  out  1  port 0 access complete, 1-cycle pulse
r1_req, r1_rw, r1_addr, r1_wdata  in  1/1/ADDR_W/DATA_W  port 1, same meaning as port 0
r1_gnt, r1_done  out  1/1  port 1, same meaning as port 0
rdata  out  DATA_W  read data, valid while the corresponding done is high
mem_en  out  1  RAM enable
mem_rw  out  1  RAM direction, 1=write
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid on last enable cycle
busy  out  1  arbiter not IDLE

Behaviour:
- Reset (g_clr low, async):
  - state=IDLE; all gnt/done/mem_en/busy=0; mem_rw=0; mem_addr, mem_wdata, rdata=0.
  - last_served=1, so port 0 wins the first contention.
  - Reset mid-access abandons the access; no done is issued.
- FSM: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - If any req is sampled high, choose a winner:
    - only one requesting -> that port;
    - both requesting -> the port != last_served.
  - Latch the winner's rw/addr/wdata into mem_rw/mem_addr/mem_wdata.
  - Set that port's gnt, load cnt=MEM_LAT-1, go to ACCESS.
- ACCESS:
  - mem_en=1, gnt held, latched command stable.
  - Requester inputs are ignored (req/addr changes have no effect).
  - Decrement cnt each cycle. At cnt==0: capture mem_rdata into rdata on reads, set last_served=winner, go to DONE.
  - mem_en is therefore high exactly MEM_LAT cycles.
- DONE:
  - mem_en=0, gnt=0, winner's done=1 for one cycle.
  - rdata holds its value until the next read completes; writes leave rdata unchanged.
  - Next state is IDLE unconditionally.
- Latency: req sampled at edge N -> mem_en high for cycles N+1..N+MEM_LAT -> done in cycle N+MEM_LAT+1. Back-to-back accesses occur every MEM_LAT+2 cycles.
- Requester rule: drop req in the cycle after done. A req still high in IDLE is a new request.
- req dropped during ACCESS: the access still completes and done still pulses (writes are never torn).
- Simultaneous new requests from both ports always alternate, so neither port starves.
- At most one gnt and one done are high in any cycle.
- busy=1 in ACCESS and DONE.

Optional Feature:
- Macro DMEM_ARB_FIXED_PRI_EN.
  - Defined: fixed priority; port 0 always wins contention and last_served is ignored. Used when cache refills must never wait behind I/O.
  - Undefined (default): round-robin as above.
- All other timing is identical in both builds.

Test Plan:
- Reset then r0_req=1, rw=0, addr=0x05, RAM[5]=0xA7, MEM_LAT=2 -> mem_en high 2 cycles with mem_addr=0x05; r0_done pulses one cycle later with rdata=0xA7; r1_gnt never high.
- r1 write addr=0x0C, wdata=0x3E -> mem_rw=1 and mem_wdata=0x3E during both enable cycles; r1_done pulses; RAM[0x0C]=0x3E; rdata unchanged.
- Both req held high for 4 accesses -> grant order r0, r1, r0, r1, each access 4 cycles apart. With DMEM_ARB_FIXED_PRI_EN defined -> r0 every time.
- r0 request, then r0_req dropped and addr changed in the first ACCESS cycle -> original address still accessed and r0_done still pulses.
- g_clr asserted low in the middle of ACCESS -> all outputs 0 immediately; after release, a simultaneous r0/r1 request grants r0 first.
- Sweep MEM_LAT=1 and MEM_LAT=7 -> mem_en width equals MEM_LAT and done arrives MEM_LAT+1 cycles after the request is sampled.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the single-port data RAM: cache fill/writeback (port 0) and I/O transfer (port 1).
// Round-robin on contention; define DMEM_ARB_FIXED_PRI_EN to make port 0 always win contention instead.
module dmem_port_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 2
) (
  input  logic              g_clk,
  input  logic              g_clr,
  input  logic              r0_req,
  input  logic              r0_rw,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_done,
  input  logic              r1_req,
  input  logic              r1_rw,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_done,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [2:0] CNT_LOAD = 3'(MEM_LAT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] cnt;
  logic       winner;       // 0 = port 0, 1 = port 1
  logic       last_served;
  logic       any_req;
  logic       pick;

  // Winner selection, only consumed while IDLE.
  always_comb begin
    any_req = r0_req | r1_req;
`ifdef DMEM_ARB_FIXED_PRI_EN
    pick = ~r0_req;
`else
    if (r0_req && r1_req) pick = ~last_served;
    else                  pick = ~r0_req;
`endif
  end

  // NOTE: async reset uses non-blocking assignments like every other sequential update.
  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  if (cnt == 3'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch, access counter and read-data capture.
  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      cnt         <= 3'd0;
      winner      <= 1'b0;
      last_served <= 1'b1;
      mem_rw      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rdata       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            winner    <= pick;
            mem_rw    <= pick ? r1_rw    : r0_rw;
            mem_addr  <= pick ? r1_addr  : r0_addr;
            mem_wdata <= pick ? r1_wdata : r0_wdata;
            cnt       <= CNT_LOAD;
          end
        end
        ACCESS: begin
          if (cnt == 3'd0) begin
            if (!mem_rw) rdata <= mem_rdata;
            last_served <= winner;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_en  = (state == ACCESS);
    busy    = (state != IDLE);
    r0_gnt  = mem_en & ~winner;
    r1_gnt  = mem_en &  winner;
    r0_done = (state == DONE) & ~winner;
    r1_done = (state == DONE) &  winner;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed vector table, multi-cycle corner sequences,
// a MEM_LAT sweep on extra instances and a randomized run against a transaction-level model.
module tb_dmem_port_arbiter;

  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int LAT = 2;
`ifdef DMEM_ARB_FIXED_PRI_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          g_clk = 1'b0;
  logic          g_clr = 1'b0;
  logic          r0_req = 1'b0, r0_rw = 1'b0;
  logic [AW-1:0] r0_addr = '0;
  logic [DW-1:0] r0_wdata = '0;
  logic          r1_req = 1'b0, r1_rw = 1'b0;
  logic [AW-1:0] r1_addr = '0;
  logic [DW-1:0] r1_wdata = '0;
  logic          r0_gnt, r0_done, r1_gnt, r1_done, mem_en, mem_rw, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, rdata;

  logic          l1_gnt0, l1_gnt1, l1_done0, l1_done1, l1_en, l1_rw, l1_busy;
  logic [AW-1:0] l1_addr;
  logic [DW-1:0] l1_wdata, l1_rdin, l1_rdata;
  logic          l7_gnt0, l7_gnt1, l7_done0, l7_done1, l7_en, l7_rw, l7_busy;
  logic [AW-1:0] l7_addr;
  logic [DW-1:0] l7_wdata, l7_rdin, l7_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 g_clk = ~g_clk;

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) u_dut (
    .g_clk(g_clk), .g_clr(g_clr),
    .r0_req(r0_req), .r0_rw(r0_rw), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_done(r0_done),
    .r1_req(r1_req), .r1_rw(r1_rw), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_done(r1_done),
    .rdata(rdata), .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Latency sweep instances share the requester inputs; they only read the RAM.
  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_lat1 (
    .g_clk(g_clk), .g_clr(g_clr),
    .r0_req(r0_req), .r0_rw(r0_rw), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(l1_gnt0), .r0_done(l1_done0),
    .r1_req(r1_req), .r1_rw(r1_rw), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(l1_gnt1), .r1_done(l1_done1),
    .rdata(l1_rdata), .mem_en(l1_en), .mem_rw(l1_rw), .mem_addr(l1_addr),
    .mem_wdata(l1_wdata), .mem_rdata(l1_rdin), .busy(l1_busy)
  );

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(7)) u_lat7 (
    .g_clk(g_clk), .g_clr(g_clr),
    .r0_req(r0_req), .r0_rw(r0_rw), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(l7_gnt0), .r0_done(l7_done0),
    .r1_req(r1_req), .r1_rw(r1_rw), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(l7_gnt1), .r1_done(l7_done1),
    .rdata(l7_rdata), .mem_en(l7_en), .mem_rw(l7_rw), .mem_addr(l7_addr),
    .mem_wdata(l7_wdata), .mem_rdata(l7_rdin), .busy(l7_busy)
  );

  // Behavioural RAM: combinational read, write on every enabled write cycle.
  logic [DW-1:0] ram [256];
  logic          ram_loaded = 1'b0;
  assign mem_rdata = ram[mem_addr];
  assign l1_rdin   = ram[l1_addr];
  assign l7_rdin   = ram[l7_addr];

  always @(posedge g_clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'h5A;
      ram[5]     <= 8'hA7;
      ram_loaded <= 1'b1;
    end else if (mem_en && mem_rw) begin
      ram[mem_addr] <= mem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {busy, mem_en, mem_rw, r0_gnt, r1_gnt, r0_done, r1_done, 1'b0, mem_addr, mem_wdata, rdata};
  endfunction

  task automatic do_reset();
    g_clr  = 1'b0;
    r0_req = 1'b0;
    r1_req = 1'b0;
    tick();
    tick();
    g_clr = 1'b1;
  endtask

  typedef struct {
    bit            port;
    bit            rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  // One isolated request; measures enable width, done offset, command stability and rdata.
  task automatic run_single(input int idx, input vec_t v);
    int en_cnt = 0, done_at = -1, bad_cmd = 0, other = 0;
    if (!v.port) begin
      r0_req = 1'b1; r0_rw = v.rw; r0_addr = v.addr; r0_wdata = v.wdata;
    end else begin
      r1_req = 1'b1; r1_rw = v.rw; r1_addr = v.addr; r1_wdata = v.wdata;
    end
    for (int j = 0; j < LAT + 4; j++) begin
      tick();
      if (mem_en) begin
        en_cnt++;
        if (mem_addr !== v.addr || mem_rw !== v.rw || (v.rw && mem_wdata !== v.wdata)) bad_cmd++;
      end
      if (v.port ? (r0_gnt | r0_done) : (r1_gnt | r1_done)) other++;
      if ((v.port ? r1_done : r0_done) && done_at < 0) begin
        done_at = j;
        check($sformatf("vec%0d_rdata", idx), rdata, v.exp_rdata);
        r0_req = 1'b0;
        r1_req = 1'b0;
      end
    end
    check($sformatf("vec%0d_en_width", idx), en_cnt, LAT);
    check($sformatf("vec%0d_done_at", idx), done_at, LAT);
    check($sformatf("vec%0d_cmd_stable", idx), bad_cmd, 0);
    check($sformatf("vec%0d_other_port", idx), other, 0);
    if (v.rw) check($sformatf("vec%0d_ram", idx), ram[v.addr], v.wdata);
  endtask

  initial begin
    vec_t vecs[7];
    // RAM starts as ram[i] = i ^ 0x5A, except ram[5] = 0xA7.
    vecs[0] = '{port: 1'b0, rw: 1'b0, addr: 8'h05, wdata: 8'h00, exp_rdata: 8'hA7};
    vecs[1] = '{port: 1'b1, rw: 1'b1, addr: 8'h0C, wdata: 8'h3E, exp_rdata: 8'hA7};
    vecs[2] = '{port: 1'b0, rw: 1'b0, addr: 8'h0C, wdata: 8'h11, exp_rdata: 8'h3E};
    vecs[3] = '{port: 1'b1, rw: 1'b0, addr: 8'h20, wdata: 8'h00, exp_rdata: 8'h7A};
    vecs[4] = '{port: 1'b0, rw: 1'b1, addr: 8'hFF, wdata: 8'h81, exp_rdata: 8'h7A};
    vecs[5] = '{port: 1'b1, rw: 1'b0, addr: 8'hFF, wdata: 8'hC3, exp_rdata: 8'h81};
    vecs[6] = '{port: 1'b0, rw: 1'b0, addr: 8'h00, wdata: 8'h00, exp_rdata: 8'h5A};

    // Reset state.
    tick();
    tick();
    check("reset_outputs", outs(), 32'h0);
    g_clr = 1'b1;
    tick();
    check("idle_after_reset", outs(), 32'h0);

    for (int i = 0; i < 7; i++) run_single(i, vecs[i]);

    // Contention: both held, expect alternation (or port 0 only with fixed priority), 4 cycles apart.
    begin
      int  n_gnt = 0;
      bit  gp [8];
      int  gc [8];
      logic p0 = 1'b0, p1 = 1'b0;
      do_reset();
      r0_req = 1'b1; r0_rw = 1'b0; r0_addr = 8'h01;
      r1_req = 1'b1; r1_rw = 1'b0; r1_addr = 8'h02;
      for (int j = 0; j < 16; j++) begin
        tick();
        if ((r0_gnt && !p0) || (r1_gnt && !p1)) begin
          if (n_gnt < 8) begin
            gp[n_gnt] = r1_gnt;
            gc[n_gnt] = j;
          end
          n_gnt++;
        end
        p0 = r0_gnt;
        p1 = r1_gnt;
      end
      r0_req = 1'b0;
      r1_req = 1'b0;
      tick();
      tick();
      check("contend_count", n_gnt, 4);
      for (int i = 0; i < 4 && i < n_gnt; i++) begin
        check($sformatf("contend_port%0d", i), gp[i], FIXED ? 1'b0 : 1'(i % 2));
        check($sformatf("contend_cycle%0d", i), gc[i], i * (LAT + 2));
      end
    end

    // Request dropped and address changed in the first ACCESS cycle.
    begin
      int en_cnt = 0, bad = 0, done_at = -1;
      r0_req = 1'b1; r0_rw = 1'b0; r0_addr = 8'h33;
      for (int j = 0; j < LAT + 4; j++) begin
        tick();
        if (j == 0) begin
          r0_req  = 1'b0;
          r0_addr = 8'h05;
        end
        if (mem_en) begin
          en_cnt++;
          if (mem_addr !== 8'h33) bad++;
        end
        if (r0_done && done_at < 0) begin
          done_at = j;
          check("drop_rdata", rdata, 8'h69);
        end
      end
      check("drop_en_width", en_cnt, LAT);
      check("drop_addr_held", bad, 0);
      check("drop_done_at", done_at, LAT);
    end

    // Async reset in the middle of an access, then contention must go to port 0.
    begin
      int r1_seen = 0;
      r1_req = 1'b1; r1_rw = 1'b0; r1_addr = 8'h40;
      tick();
      check("mid_access_gnt", r1_gnt, 1'b1);
      g_clr = 1'b0;
      #1;
      check("async_reset_outputs", outs(), 32'h0);
      r1_req = 1'b0;
      tick();
      tick();
      check("held_reset_no_done", outs(), 32'h0);
      g_clr = 1'b1;
      tick();
      check("post_reset_idle", outs(), 32'h0);
      r0_req = 1'b1; r0_addr = 8'h06;
      r1_req = 1'b1; r1_addr = 8'h07;
      tick();
      check("post_reset_r0_first", {r0_gnt, r1_gnt}, 2'b10);
      r0_req = 1'b0;
      r1_req = 1'b0;
      for (int j = 0; j < LAT + 3; j++) begin
        tick();
        if (r1_gnt || r1_done) r1_seen++;
      end
      check("post_reset_r1_quiet", r1_seen, 0);
    end

    // MEM_LAT sweep: single sampled request seen by all three instances.
    begin
      int en1 = 0, en7 = 0, d1 = -1, d7 = -1;
      do_reset();
      r0_req = 1'b1; r0_rw = 1'b0; r0_addr = 8'h05;
      for (int j = 0; j < 11; j++) begin
        tick();
        if (j == 0) r0_req = 1'b0;
        if (l1_en) en1++;
        if (l7_en) en7++;
        if (l1_done0 && d1 < 0) d1 = j;
        if (l7_done0 && d7 < 0) d7 = j;
      end
      check("lat1_en_width", en1, 1);
      check("lat1_done_at", d1, 1);
      check("lat1_rdata", l1_rdata, 8'hA7);
      check("lat7_en_width", en7, 7);
      check("lat7_done_at", d7, 7);
      check("lat7_rdata", l7_rdata, 8'hA7);
    end

    // Randomized run against a transaction-level model.
    begin
      logic [DW-1:0] ref_ram [256];
      int            next_free = 0, s = -1;
      bit            last = 1'b1, win = 1'b0, c_rw = 1'b0, en, dn;
      logic [AW-1:0] c_addr = '0;
      logic [DW-1:0] c_wdata = '0, cur_rdata = '0, pend_rdata = '0;
      do_reset();
      for (int i = 0; i < 256; i++) ref_ram[i] = ram[i];
      for (int k = 0; k < 600; k++) begin
        if (k >= next_free && (r0_req || r1_req)) begin
          if (r0_req && r1_req) win = FIXED ? 1'b0 : ~last;
          else                  win = ~r0_req;
          last      = win;
          s         = k;
          next_free = k + LAT + 2;
          c_rw      = win ? r1_rw    : r0_rw;
          c_addr    = win ? r1_addr  : r0_addr;
          c_wdata   = win ? r1_wdata : r0_wdata;
          if (c_rw) ref_ram[c_addr] = c_wdata;
          else      pend_rdata      = ref_ram[c_addr];
        end
        tick();
        en = (s >= 0) && (k >= s) && (k <= s + LAT - 1);
        dn = (s >= 0) && (k == s + LAT);
        if (dn && !c_rw) cur_rdata = pend_rdata;
        check($sformatf("rand_cycle%0d", k), outs(),
              {en | dn, en, c_rw, en & ~win, en & win, dn & ~win, dn & win, 1'b0,
               c_addr, c_wdata, cur_rdata});
        if (dn && !win)              r0_req = 1'b0;
        else if (!r0_req)            r0_req = ($urandom % 3 == 0);
        if (dn && win)               r1_req = 1'b0;
        else if (!r1_req)            r1_req = ($urandom % 3 == 0);
        r0_rw = 1'($urandom); r0_addr = 8'($urandom % 16); r0_wdata = 8'($urandom);
        r1_rw = 1'($urandom); r1_addr = 8'($urandom % 16); r1_wdata = 8'($urandom);
      end
      r0_req = 1'b0;
      r1_req = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
